// File: rtl/frame_pkg.sv
// Shared definitions for the frame capture sequencer: default geometry,
// counter width and FSM state encoding.
package frame_pkg;

    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int CNT_W_DEF = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pixel_window_check.sv
// Combinational classification of the camera pixel: inside the frame window,
// frame-start position (1,0) and last pixel position (IMG_W, IMG_H-1).
module pixel_window_check
    import frame_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic [9:0] i_xIndex,
    input  logic [9:0] i_yIndex,
    input  logic       i_pixValid,
    output logic       o_inFrame,
    output logic       o_frameStart,
    output logic       o_lastPixel
);

    localparam logic [9:0] X_MAX = 10'(IMG_W);
    localparam logic [9:0] Y_MAX = 10'(IMG_H - 1);

    // Columns are numbered from 1, lines from 0.
    assign o_inFrame    = i_pixValid && (i_xIndex != 10'd0) && (i_xIndex <= X_MAX)
                          && (i_yIndex <= Y_MAX);
    assign o_frameStart = i_pixValid && (i_xIndex == 10'd1) && (i_yIndex == 10'd0);
    assign o_lastPixel  = i_pixValid && (i_xIndex == X_MAX) && (i_yIndex == Y_MAX);

endmodule

// File: rtl/frame_capture_sequencer.sv
// Captures one camera frame into the frame FIFO on host request and drains it
// to the accelerator; write and read strobes are zero-latency combinational.
module frame_capture_sequencer
    import frame_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [9:0]       i_xIndex,
    input  logic [9:0]       i_yIndex,
    input  logic             i_pixValid,
    input  logic             i_fifoFull,
    input  logic             i_fifoEmpty,
    input  logic             i_accReady,
    output logic             o_eWriteFifo,
    output logic             o_eReadFifo,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_pixCount
);

    localparam logic [CNT_W-1:0] PIX_MAX = CNT_W'(IMG_W * IMG_H);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic             r_overflow;

    logic w_in_frame;
    logic w_frame_start;
    logic w_last_pixel;
    logic w_kill;
    logic w_capturing;
    logic w_qualify;
    logic w_write;
    logic w_drop;
    logic w_read;

    pixel_window_check #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_window (
        .i_xIndex     (i_xIndex),
        .i_yIndex     (i_yIndex),
        .i_pixValid   (i_pixValid),
        .o_inFrame    (w_in_frame),
        .o_frameStart (w_frame_start),
        .o_lastPixel  (w_last_pixel)
    );

    // Reset and abort silence every strobe in the cycle they are asserted.
    assign w_kill      = i_reset || i_abort;
    assign w_capturing = (r_state == ST_CAPTURE) || ((r_state == ST_ARM) && w_frame_start);
    assign w_qualify   = w_in_frame && w_capturing && !w_kill;
    assign w_write     = w_qualify && !i_fifoFull && (r_wr_cnt != PIX_MAX);
    assign w_drop      = w_qualify && i_fifoFull;
    assign w_read      = ((r_state == ST_CAPTURE) || (r_state == ST_DRAIN)) && !i_fifoEmpty
                         && i_accReady && (r_rd_cnt != r_wr_cnt) && !w_kill;

    assign o_eWriteFifo = w_write;
    assign o_eReadFifo  = w_read;
    assign o_busy       = (r_state != ST_IDLE) && !i_reset;
    assign o_done       = (r_state == ST_DONE) && !w_kill;
    assign o_overflow   = r_overflow;
    assign o_pixCount   = r_wr_cnt;

    always_comb begin
        // NOTE: default assigned first so no path leaves the next state unassigned (no latch).
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (i_start) w_state_next = ST_ARM;
            ST_ARM:     if (w_frame_start) w_state_next = w_last_pixel ? ST_DRAIN : ST_CAPTURE;
            ST_CAPTURE: if (w_last_pixel) w_state_next = ST_DRAIN;
            ST_DRAIN:   if (r_rd_cnt == r_wr_cnt) w_state_next = ST_DONE;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
        if (i_abort) w_state_next = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        // NOTE: synchronous reset with non-blocking updates; all state moves together on the edge.
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && i_start && !i_abort) begin
                r_wr_cnt   <= '0;
                r_rd_cnt   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_write) r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_read)  r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_drop)  r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/frame_capture_sequencer.md
FRAME_CAPTURE_SEQUENCER -- requirements
Module: frame_capture_sequencer

Interface
REQ-001 SHALL have parameter IMG_W, default 320, pixels per line; valid x range 1..IMG_W.
REQ-002 SHALL have parameter IMG_H, default 240, lines per frame; valid y range 0..IMG_H-1.
REQ-003 SHALL have parameter CNT_W, default 17, pixel counter width (holds IMG_W*IMG_H).
REQ-004 i_clk  input  1  clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_start  input  1  host request to capture one frame; level-sampled.
REQ-007 i_abort  input  1  cancel the current capture/drain.
REQ-008 i_xIndex  input  10  camera column index.
REQ-009 i_yIndex  input  10  camera line index.
REQ-010 i_pixValid  input  1  camera pixel at (i_xIndex, i_yIndex) is valid this cycle.
REQ-011 i_fifoFull  input  1  frame FIFO cannot accept a write.
REQ-012 i_fifoEmpty  input  1  frame FIFO has no data.
REQ-013 i_accReady  input  1  accelerator accepts a pixel this cycle.
REQ-014 o_eWriteFifo  output  1  FIFO write strobe.
REQ-015 o_eReadFifo  output  1  FIFO read strobe toward accelerator.
REQ-016 o_busy  output  1  high in any state except IDLE.
REQ-017 o_done  output  1  one-cycle frame-complete pulse.
REQ-018 o_overflow  output  1  sticky: a valid in-frame pixel was dropped on full.
REQ-019 o_pixCount  output  CNT_W  pixels written in the current/last frame.

Function
REQ-020 FSM states SHALL be IDLE, ARM, CAPTURE, DRAIN, DONE; state register only.
REQ-021 IDLE: i_start=1 -> ARM next cycle; wrCnt, rdCnt, o_overflow cleared on that edge.
REQ-022 Frame start SHALL be i_pixValid=1 with x=1, y=0; ARM waits for it, ignoring all other pixels.
REQ-023 Qualifying pixel SHALL be i_pixValid=1, 1<=x<=IMG_W, y<=IMG_H-1, in CAPTURE or the frame-start cycle in ARM.
REQ-024 o_eWriteFifo SHALL be combinational: qualifying pixel AND !i_fifoFull; same cycle as the pixel, zero latency.
REQ-025 Qualifying pixel with i_fifoFull=1 SHALL not be written and SHALL set o_overflow next edge; capture continues.
REQ-026 wrCnt SHALL increment on every o_eWriteFifo; o_pixCount = wrCnt.
REQ-027 ARM -> CAPTURE on the frame-start cycle; CAPTURE -> DRAIN on the cycle after the pixel (IMG_W, IMG_H-1) is seen valid (written or dropped).
REQ-028 o_eReadFifo SHALL be combinational: (CAPTURE or DRAIN) AND !i_fifoEmpty AND i_accReady AND rdCnt != wrCnt; rdCnt increments on each.
REQ-029 Simultaneous write and read in one cycle SHALL both be issued and both counters update.
REQ-030 DRAIN -> DONE when rdCnt == wrCnt (registered values); DONE lasts exactly one cycle with o_done=1, then IDLE.
REQ-031 i_abort=1 in ARM, CAPTURE, DRAIN or DONE SHALL force IDLE next edge, no o_done, strobes deasserted that cycle; o_overflow and o_pixCount hold; i_abort has priority over every transition.
REQ-032 i_start outside IDLE SHALL be ignored; i_start held high after DONE starts a new frame from IDLE.
REQ-033 Counters SHALL not wrap: max wrCnt = IMG_W*IMG_H; pixels outside range never counted.

Reset
REQ-034 i_reset=1 SHALL force IDLE, wrCnt=0, rdCnt=0, o_overflow=0, o_done=0 next edge, overriding i_start/i_abort.
REQ-035 During reset, o_eWriteFifo, o_eReadFifo, o_busy SHALL be 0; reset mid-frame discards progress.

Structure
REQ-036 FSM state encoding, default IMG_W/IMG_H and CNT_W SHALL live in shared package frame_pkg.
REQ-037 Single sub-module pixel_window_check (combinational in-frame/frame-start/last-pixel flags) SHALL be used; counters and FSM stay in top.

Verification
REQ-038 IMG_W=4, IMG_H=3, no backpressure, i_accReady=1: i_start -> 12 writes, 12 reads, o_done one cycle, o_pixCount=12, o_overflow=0.
REQ-039 i_start mid-frame at (2,1) -> no writes until next (1,0); then full 12-pixel frame captured.
REQ-040 i_fifoFull=1 for pixels (3,0),(4,0) -> 10 writes, o_overflow=1 sticky, o_done still pulses with o_pixCount=10.
REQ-041 i_accReady=0 throughout CAPTURE, then 1 -> DRAIN reads 12 pixels one per cycle, DONE after rdCnt=12.
REQ-042 i_abort in CAPTURE after 5 writes -> IDLE next cycle, no o_done, o_pixCount=5; new i_start clears to 0.
REQ-043 Default 320x240, i_reset pulsed at (100,50) -> all outputs 0, IDLE; subsequent i_start captures 76800 pixels.
